// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation modes,
// per-bit cell mux selects and the legal-width check.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // LO takes the lower-index neighbour (left shift), HI the higher one (right shift).
  localparam logic [2:0] CELL_HOLD = 3'd0;
  localparam logic [2:0] CELL_LOAD = 3'd1;
  localparam logic [2:0] CELL_LO   = 3'd2;
  localparam logic [2:0] CELL_HI   = 3'd3;
  localparam logic [2:0] CELL_ZERO = 3'd4;

  function automatic bit usr_width_ok(input int w);
    return (w >= 2) && (w <= 64);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the shift register: next-state mux feeding a
// rising-edge flop with a synchronous per-bit reset value.
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst_val_i,
  input  logic [2:0] sel_i,
  input  logic       load_i,
  input  logic       lo_i,
  input  logic       hi_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      CELL_LOAD: q_d = load_i;
      CELL_LO:   q_d = lo_i;
      CELL_HI:   q_d = hi_i;
      CELL_ZERO: q_d = 1'b0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= rst_val_i;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, load, shifts, rotates, ASR and
// clear, built from per-bit cells with end-bit selection and a Carry flop.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInL,
  input  logic             SerInR,
  output logic [WIDTH-1:0] Q,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Zero,
  output logic             Carry
);

  if (!usr_width_ok(WIDTH)) begin : g_width_err
    $error("universal_shift_register: WIDTH must be in 2..64");
  end

  logic [2:0]       cell_sel;
  logic             carry_q;
  logic             carry_d;
  logic             lo_end;
  logic             hi_end;
  logic [WIDTH-1:0] lo_vec;
  logic [WIDTH-1:0] hi_vec;

  // One select is shared by every bit; only the two end bits differ in source.
  always_comb begin
    cell_sel = CELL_HOLD;
    carry_d  = carry_q;
    if (En) begin
      case (Mode)
        MODE_LOAD: cell_sel = CELL_LOAD;
        MODE_SHL, MODE_ROL: begin
          cell_sel = CELL_LO;
          carry_d  = Q[WIDTH-1];
        end
        MODE_SHR, MODE_ROR, MODE_ASR: begin
          cell_sel = CELL_HI;
          carry_d  = Q[0];
        end
        MODE_CLR: begin
          cell_sel = CELL_ZERO;
          carry_d  = 1'b0;
        end
        default: cell_sel = CELL_HOLD;
      endcase
    end
  end

  always_comb begin
    lo_end = (Mode == MODE_ROL) ? Q[WIDTH-1] : SerInL;
    case (Mode)
      MODE_ROR: hi_end = Q[0];
      MODE_ASR: hi_end = Q[WIDTH-1];
      default:  hi_end = SerInR;
    endcase
  end

  assign lo_vec = {Q[WIDTH-2:0], lo_end};
  assign hi_vec = {hi_end, Q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .rst_val_i (RESET_VAL[i]),
      .sel_i     (cell_sel),
      .load_i    (D[i]),
      .lo_i      (lo_vec[i]),
      .hi_i      (hi_vec[i]),
      .q_o       (Q[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign Carry   = carry_q;
  assign SerOutL = Q[WIDTH-1];
  assign SerOutR = Q[0];
  assign Zero    = (Q == '0);

endmodule
